// File: rtl/ma_pkg.sv
// Shared constants, result field layout and FSM state type for the MA peak detector family.
package ma_pkg;

  localparam int WORD_LENGTH = 16;

  // Width of the moving-average output word derived from the CMUL input sample width.
  function automatic int ma_data_w(input int word_length);
    return (word_length * 2 + 3) * 2 + 1;
  endfunction

  localparam int DATA_W        = ma_data_w(WORD_LENGTH);
  localparam int IDX_W         = 10;
  localparam int MAX_FRAME_LEN = 1 << IDX_W;
  localparam int RES_W         = DATA_W + IDX_W + 1;

  localparam int PK_VAL_LSB = 0;
  localparam int PK_IDX_LSB = DATA_W;
  localparam int PK_OVF_BIT = DATA_W + IDX_W;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

endpackage

// File: rtl/ma_peak_cmp.sv
// Combinational signed peak compare: take the candidate on the first beat or when strictly larger.
module ma_peak_cmp #(
  parameter int W = 71
) (
  input  logic         first,
  input  logic [W-1:0] cand,
  input  logic [W-1:0] cur,
  output logic         upd
);

  // Strict greater-than keeps the earliest sample on ties.
  assign upd = first || ($signed(cand) > $signed(cur));

endmodule

// File: rtl/ma_peak_detect.sv
// Per-frame peak value/index detector on the MA output stream, one result beat per frame.
// Optional MA_PEAK_THRESHOLD_EN adds a threshold port that suppresses sub-threshold results.
module ma_peak_detect
  import ma_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
`ifdef MA_PEAK_THRESHOLD_EN
  input  logic [DATA_W-1:0] threshold,
`endif
  output logic [RES_W-1:0]  m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              ovf_sticky,
  output state_t            dbg_state
);

  // Handshakes: a beat transfers on the rising edge where valid && ready are both high;
  // m_tvalid/m_tdata never change while m_tvalid is high and m_tready is low.

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  peak_idx;
  logic [DATA_W-1:0] peak_val;
  logic              armed;
  logic              accept;
  logic              upd;
  logic              close;
  logic              forced;
  logic              keep;
  logic [DATA_W-1:0] nxt_val;
  logic [IDX_W-1:0]  nxt_idx;
  logic [RES_W-1:0]  res;

`ifdef MA_PEAK_THRESHOLD_EN
  logic bubble;
  assign s_tready = armed && en && (state == ACCUM) && !bubble;
  assign keep     = !($signed(nxt_val) < $signed(threshold));
`else
  assign s_tready = armed && en && (state == ACCUM);
  assign keep     = 1'b1;
`endif

  assign accept = s_tvalid && s_tready;

  ma_peak_cmp #(.W(DATA_W)) u_cmp (
    .first (idx == '0),
    .cand  (s_tdata),
    .cur   (peak_val),
    .upd   (upd)
  );

  assign nxt_val = upd ? s_tdata : peak_val;
  assign nxt_idx = upd ? idx : peak_idx;

  // The last index slot closes the frame even without tlast.
  assign forced = !s_tlast && (&idx);
  assign close  = accept && (s_tlast || (&idx));

  always_comb begin
    res = '0;
    res[PK_VAL_LSB +: DATA_W] = nxt_val;
    res[PK_IDX_LSB +: IDX_W]  = nxt_idx;
    res[PK_OVF_BIT]           = forced;
  end

  assign m_tlast   = m_tvalid;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      idx        <= '0;
      peak_val   <= '0;
      peak_idx   <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      ovf_sticky <= 1'b0;
      armed      <= 1'b0;
`ifdef MA_PEAK_THRESHOLD_EN
      bubble     <= 1'b0;
`endif
    end else begin
      armed <= 1'b1;
`ifdef MA_PEAK_THRESHOLD_EN
      bubble <= 1'b0;
`endif
      case (state)
        ACCUM: begin
          if (accept) begin
            peak_val <= nxt_val;
            peak_idx <= nxt_idx;
            idx      <= idx + IDX_W'(1);
            if (close) begin
              idx <= '0;
              if (forced) ovf_sticky <= 1'b1;
              if (keep) begin
                m_tdata  <= res;
                m_tvalid <= 1'b1;
                state    <= REPORT;
              end
`ifdef MA_PEAK_THRESHOLD_EN
              else begin
                bubble <= 1'b1;
              end
`endif
            end
          end
        end
        REPORT: begin
          if (m_tready) begin
            m_tvalid <= 1'b0;
            idx      <= '0;
            state    <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_ma_peak_detect.sv
// Self-checking bench for ma_peak_detect: scoreboard of expected result beats plus per-scenario checks.
module tb_ma_peak_detect;
  import ma_pkg::*;

  localparam int DW = DATA_W;
  localparam int RW = RES_W;

  logic          clk;
  logic          rst;
  logic          en;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [RW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic          ovf_sticky;
  state_t        dbg_state;
`ifdef MA_PEAK_THRESHOLD_EN
  logic [DW-1:0] threshold;
`endif

  int errors = 0;
  int checks = 0;
  int gap_pct = 0;
  int drop_pct = 0;

  logic [RW-1:0]        exp_q[$];
  logic signed [DW-1:0] fq[$];

  ma_peak_detect dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
`ifdef MA_PEAK_THRESHOLD_EN
    .threshold  (threshold),
`endif
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .ovf_sticky (ovf_sticky),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sx(input int v);
    return DW'(v);
  endfunction

  function automatic logic [RW-1:0] pack(input logic ovf, input logic [IDX_W-1:0] i,
                                         input logic [DW-1:0] v);
    return {ovf, i, v};
  endfunction

  // Reference peak of the frame held in fq: first sample, then strictly larger ones.
  function automatic logic [RW-1:0] model_peak();
    logic signed [DW-1:0] best;
    int bi;
    best = fq[0];
    bi = 0;
    for (int i = 1; i < fq.size(); i++) begin
      if (fq[i] > best) begin
        best = fq[i];
        bi = i;
      end
    end
    return pack(1'b0, IDX_W'(bi), best);
  endfunction

  // scoreboard: every result handshake pops one expected word
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (!rst && m_tvalid && m_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got=%h", m_tdata);
      end else begin
        e = exp_q.pop_front();
        if (m_tdata !== e) begin
          errors++;
          $display("FAIL result_beat got=%h exp=%h", m_tdata, e);
        end
      end
      checks++;
      if (m_tlast !== 1'b1) begin
        errors++;
        $display("FAIL m_tlast got=%b exp=1", m_tlast);
      end
    end
  end

  // driver: present one beat, with optional idle gaps and en drops, until accepted
  task automatic drive_beat(input logic [DW-1:0] d, input logic last);
    int n;
    while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
      s_tvalid = 1'b0;
      en = ($urandom_range(99) < drop_pct) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    n = 0;
    forever begin
      en = (drop_pct > 0 && $urandom_range(99) < drop_pct) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (s_tready) break;
      @(posedge clk); #1;
      n++;
      if (n > 3000) begin
        errors++;
        checks++;
        $display("FAIL accept_timeout got=no_ready exp=ready");
        s_tvalid = 1'b0;
        en = 1'b1;
        return;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    en       = 1'b1;
  endtask

  task automatic run_frame();
    exp_q.push_back(model_peak());
    for (int i = 0; i < fq.size(); i++) drive_beat(fq[i], i == fq.size() - 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d_pending exp=0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks += 5;
    if (s_tready !== 1'b0)   begin errors++; $display("FAIL rst_s_tready got=%b exp=0", s_tready); end
    if (m_tvalid !== 1'b0)   begin errors++; $display("FAIL rst_m_tvalid got=%b exp=0", m_tvalid); end
    if (m_tdata !== '0)      begin errors++; $display("FAIL rst_m_tdata got=%h exp=0", m_tdata); end
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", ovf_sticky); end
    if (dbg_state !== ACCUM) begin errors++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_basic();
    logic [RW-1:0] e;
    fq = {};
    fq.push_back(sx(3)); fq.push_back(sx(9)); fq.push_back(sx(-2)); fq.push_back(sx(9));
    e = pack(1'b0, IDX_W'(1), sx(9));
    run_frame();
    // one clock after the tlast handshake the result must be presented
    checks += 2;
    if (m_tvalid !== 1'b1) begin errors++; $display("FAIL basic_latency got=%b exp=1", m_tvalid); end
    if (m_tdata !== e)     begin errors++; $display("FAIL basic_data got=%h exp=%h", m_tdata, e); end
    wait_drain();
  endtask

  task automatic test_negative();
    fq = {};
    fq.push_back(sx(-5)); fq.push_back(sx(-7)); fq.push_back(sx(-1));
    exp_q.push_back(pack(1'b0, IDX_W'(2), sx(-1)));
    for (int i = 0; i < fq.size(); i++) drive_beat(fq[i], i == fq.size() - 1);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] e;
    e = pack(1'b0, IDX_W'(2), sx(3));
    m_tready = 1'b0;
    fq = {};
    fq.push_back(sx(1)); fq.push_back(sx(2)); fq.push_back(sx(3));
    run_frame();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 3;
      if (m_tvalid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, m_tvalid); end
      if (m_tdata !== e)     begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, m_tdata, e); end
      if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_s_tready cyc=%0d got=%b exp=0", i, s_tready); end
      @(posedge clk); #1;
    end
    m_tready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_tready !== 1'b1) begin errors++; $display("FAIL bp_release got=%b exp=1", s_tready); end
    wait_drain();
  endtask

  task automatic test_overflow();
    logic signed [DW-1:0] v;
    exp_q.push_back(pack(1'b1, IDX_W'(700), sx(100)));
    exp_q.push_back(pack(1'b0, IDX_W'(0), sx(42)));
    for (int i = 0; i < MAX_FRAME_LEN; i++) begin
      v = (i == 700) ? sx(100) : sx(int'($urandom_range(0, 199)) - 100);
      drive_beat(v, 1'b0);
    end
    drive_beat(sx(42), 1'b1);
    wait_drain();
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_sticky); end
  endtask

  task automatic test_gaps_en();
    fq = {};
    for (int i = 0; i < 20; i++) fq.push_back(sx(int'($urandom_range(0, 2000)) - 1000));
    run_frame();
    wait_drain();
    gap_pct = 40;
    drop_pct = 30;
    run_frame();
    wait_drain();
    gap_pct = 0;
    drop_pct = 0;
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%b exp=1", ovf_sticky); end
  endtask

  task automatic test_rst_mid();
    drive_beat(sx(500), 1'b0);
    drive_beat(sx(600), 1'b0);
    drive_beat(sx(700), 1'b0);
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (m_tvalid !== 1'b0)   begin errors++; $display("FAIL mid_rst_valid got=%b exp=0", m_tvalid); end
    if (m_tdata !== '0)      begin errors++; $display("FAIL mid_rst_data got=%h exp=0", m_tdata); end
    if (s_tready !== 1'b0)   begin errors++; $display("FAIL mid_rst_ready got=%b exp=0", s_tready); end
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got=%b exp=0", ovf_sticky); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // single-beat frame after reset must start again at index 0
    fq = {};
    fq.push_back(sx(7));
    exp_q.push_back(pack(1'b0, IDX_W'(0), sx(7)));
    drive_beat(fq[0], 1'b1);
    wait_drain();
  endtask

`ifdef MA_PEAK_THRESHOLD_EN
  task automatic test_threshold();
    threshold = sx(50);
    drive_beat(sx(10), 1'b0);
    drive_beat(sx(49), 1'b0);
    drive_beat(sx(3), 1'b1);
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL thr_suppress got=%b exp=0", m_tvalid); end
    exp_q.push_back(pack(1'b0, IDX_W'(0), sx(50)));
    drive_beat(sx(50), 1'b0);
    drive_beat(sx(20), 1'b1);
    wait_drain();
  endtask
`endif

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
`ifdef MA_PEAK_THRESHOLD_EN
    threshold = {1'b1, {(DW-1){1'b0}}};
`endif
    test_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_basic();
    test_negative();
    test_backpressure();
    test_overflow();
    test_gaps_en();
    test_rst_mid();
`ifdef MA_PEAK_THRESHOLD_EN
    test_threshold();
`endif
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
